// File: rtl/aes_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl_if
// Bundles the signals between the AES-128 round sequencer and its
// neighbours: the plaintext input handshake, the key expander request,
// the round datapath step enables and the ciphertext output handshake.
//   master : the sequencer (drives requests, enables and handshake status)
//   slave  : the surrounding datapath / key expander / port logic
// ---------------------------------------------------------------------------
interface aes_round_ctrl_if;

  // Plaintext input handshake
  logic       in_valid;
  logic       in_ready;
  logic       load_state;

  // Key expander request
  logic       key_req;
  logic [3:0] key_round;
  logic       key_ack;

  // Round datapath step enables
  logic       enb_sb;
  logic       enbsr;
  logic       enb_mc;
  logic       enb_ark;

  // Ciphertext output handshake and status
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  modport master (
    input  in_valid,
    input  key_ack,
    input  out_ready,
    output in_ready,
    output load_state,
    output key_req,
    output key_round,
    output enb_sb,
    output enbsr,
    output enb_mc,
    output enb_ark,
    output out_valid,
    output busy
  );

  modport slave (
    output in_valid,
    output key_ack,
    output out_ready,
    input  in_ready,
    input  load_state,
    input  key_req,
    input  key_round,
    input  enb_sb,
    input  enbsr,
    input  enb_mc,
    input  enb_ark,
    input  out_valid,
    input  busy
  );

endinterface : aes_round_ctrl_if

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Round sequencer for the AES-128 encoder datapath.
//
// A plaintext block is accepted in IDLE (load_state pulses in the accept
// cycle).  In RUN the controller requests round key rnd from the key
// expander and, in the cycle the key is acknowledged, pulses the step
// enables for that round:
//   round 0        : AddRoundKey only (initial key whitening)
//   rounds 1..NR-1 : SubBytes, ShiftRows, MixColumns, AddRoundKey
//   round NR       : SubBytes, ShiftRows, AddRoundKey (no MixColumns)
// After the last round the ciphertext is offered in OUT until accepted.
//
// Optional feature (macro AES_CTRL_ABORT_EN): adds an abort input that
// drops an in-flight block in RUN or OUT and returns to IDLE.  Without the
// macro there is no abort port and a block always completes unless reset.
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
  parameter int NR = 10  // number of rounds; must fit the 4-bit round counter
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef AES_CTRL_ABORT_EN
  input  logic             abort,
`endif
  aes_round_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_t     state;
  logic [3:0] rnd;

  // Handshake/status flags are kept as flops alongside the state so the
  // Moore-type outputs come straight from registers.
  logic in_ready_q;
  logic key_req_q;
  logic out_valid_q;
  logic busy_q;

  logic abort_now;
  logic step_fire;
  logic first_rnd;
  logic last_rnd;

`ifdef AES_CTRL_ABORT_EN
  // Abort only has meaning while a block is in flight; in IDLE it is ignored
  // so the accept path is never masked.
  assign abort_now = abort & busy_q;
`else
  assign abort_now = 1'b0;
`endif

  assign first_rnd = (rnd == 4'd0);
  assign last_rnd  = (rnd == LAST_RND);

  // A round step happens exactly when a requested key arrives and the
  // block is not being dropped in the same cycle.
  assign step_fire = key_req_q & bus.key_ack & ~abort_now;

  // Per-round step enables, decoded from the round index.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    bus.enb_sb  = 1'b0;
    bus.enbsr   = 1'b0;
    bus.enb_mc  = 1'b0;
    bus.enb_ark = 1'b0;
    if (step_fire) begin
      bus.enb_ark = 1'b1;
      if (!first_rnd) begin
        bus.enb_sb = 1'b1;
        bus.enbsr  = 1'b1;
        bus.enb_mc = ~last_rnd;
      end
    end
  end

  // load_state is combinational with the accept so the datapath captures
  // the plaintext in the same cycle the handshake completes.
  assign bus.load_state = in_ready_q & bus.in_valid;
  assign bus.in_ready   = in_ready_q;
  assign bus.key_req    = key_req_q & ~abort_now;
  assign bus.out_valid  = out_valid_q & ~abort_now;
  assign bus.busy       = busy_q;
  // rnd is zero outside RUN, so it can be exported directly.
  assign bus.key_round  = rnd;

  // Sequencer FSM: state, round counter and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated only with non-blocking assignments
    // so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state       <= IDLE;
      rnd         <= 4'd0;
      in_ready_q  <= 1'b1;
      key_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= RUN;
            rnd        <= 4'd0;
            in_ready_q <= 1'b0;
            key_req_q  <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        RUN: begin
          if (abort_now) begin
            state      <= IDLE;
            rnd        <= 4'd0;
            in_ready_q <= 1'b1;
            key_req_q  <= 1'b0;
            busy_q     <= 1'b0;
          end else if (bus.key_ack) begin
            if (last_rnd) begin
              state       <= OUT;
              rnd         <= 4'd0;
              key_req_q   <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              rnd <= rnd + 4'd1;
            end
          end
        end

        OUT: begin
          if (abort_now || bus.out_ready) begin
            state       <= IDLE;
            rnd         <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          rnd         <= 4'd0;
          in_ready_q  <= 1'b1;
          key_req_q   <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the sequencer.
  a_enb_needs_ack : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.enb_sb || bus.enbsr || bus.enb_mc || bus.enb_ark) |-> (state == RUN && bus.key_ack));

  a_mc_full_round : assert property (@(posedge clk) disable iff (!rst_n)
    bus.enb_mc |-> (bus.enb_sb && bus.enbsr && bus.enb_ark));

  a_rnd_range : assert property (@(posedge clk) disable iff (!rst_n)
    rnd <= LAST_RND);

  a_key_round_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.key_req && !bus.key_ack) |=> $stable(bus.key_round));

  a_load_when_idle : assert property (@(posedge clk) disable iff (!rst_n)
    bus.load_state |-> bus.in_ready);

  a_no_overlap : assert property (@(posedge clk) disable iff (!rst_n)
    bus.out_valid |-> !bus.in_ready);

endmodule : aes_round_ctrl

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
// Directed and randomized bench for aes_round_ctrl.  The reference model
// tracks a block's progress as a single integer position (0 = idle,
// 1..NR+1 = waiting on round key pos-1, NR+2 = ciphertext offered) and
// derives the expected outputs from the round-step rules.
// Abort scenarios are exercised when AES_CTRL_ABORT_EN is defined.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

  localparam int NR     = 10;
  localparam int P_OUT  = NR + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef AES_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(.NR(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef AES_CTRL_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_pos  = 0;   // model block position
  int cyc    = 0;
  logic [12:0] obs;

  // Output vector layout:
  // [12] in_ready [11] load_state [10] key_req [9:6] key_round
  // [5] enb_sb [4] enbsr [3] enb_mc [2] enb_ark [1] out_valid [0] busy
  function automatic logic [12:0] sample();
    return {bus.in_ready, bus.load_state, bus.key_req, bus.key_round,
            bus.enb_sb, bus.enbsr, bus.enb_mc, bus.enb_ark,
            bus.out_valid, bus.busy};
  endfunction

  function automatic logic [12:0] model_out(input int pos, input logic iv,
                                            input logic ka, input logic ab);
    logic ir, ld, kr, sb, sr, mc, ark, ov, bz;
    logic [3:0] kround;
    int r;
    ir = 0; ld = 0; kr = 0; sb = 0; sr = 0; mc = 0; ark = 0; ov = 0; bz = 0;
    kround = 4'd0;
    if (pos == 0) begin
      ir = 1;
      ld = iv;
    end else if (pos <= NR + 1) begin
      r      = pos - 1;
      bz     = 1;
      kround = 4'(r);
      kr     = !ab;
      if (ka && !ab) begin
        ark = 1;
        sb  = (r >= 1);
        sr  = (r >= 1);
        mc  = (r >= 1) && (r < NR);
      end
    end else begin
      bz = 1;
      ov = !ab;
    end
    return {ir, ld, kr, kround, sb, sr, mc, ark, ov, bz};
  endfunction

  function automatic int model_next(input int pos, input logic iv, input logic ka,
                                    input logic orr, input logic ab);
    if (pos == 0)      return iv ? 1 : 0;
    if (ab)            return 0;
    if (pos <= NR + 1) return ka ? pos + 1 : pos;
    return orr ? 0 : pos;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // One clock cycle: drive just after the rising edge, compare on the
  // falling edge, then advance the model across the next rising edge.
  task automatic run_cycle(input logic iv, input logic ka, input logic orr,
                           input logic ab);
    logic ab_eff;
    bus.in_valid  = iv;
    bus.key_ack   = ka;
    bus.out_ready = orr;
`ifdef AES_CTRL_ABORT_EN
    abort  = ab;
    ab_eff = ab;
`else
    ab_eff = ab & 1'b0;  // no abort port in this build
`endif
    @(negedge clk);
    obs = sample();
    check($sformatf("cyc%0d outputs", cyc), 32'(obs),
          32'(model_out(m_pos, iv, ka, (m_pos != 0) && ab_eff)));
    @(posedge clk);
    #1;
    m_pos = model_next(m_pos, iv, ka, orr, ab_eff);
    cyc++;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && m_pos != 0; n++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    int first_out, ir13, loads, ovs, last_load, sr_cnt, stalls;

    bus.in_valid  = 1'b0;
    bus.key_ack   = 1'b0;
    bus.out_ready = 1'b0;

    // ---- reset values ----
    repeat (2) @(posedge clk);
    #1;
    obs = sample();
    check("reset outputs", 32'(obs), 32'(13'b1_0_0_0000_0000_0_0));
    check("reset key_round", 32'(obs[9:6]), 32'd0);
    rst_n = 1'b1;
    m_pos = 0;
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);

    // ---- nominal block, key_ack and out_ready tied high ----
    first_out = -1;
    ir13 = 0;
    for (int t = 0; t < 14; t++) begin
      run_cycle(t == 0, 1'b1, 1'b1, 1'b0);
      if (obs[1] && first_out < 0) first_out = t;
      if (t == 13) ir13 = int'(obs[12]);
    end
    check("nominal first out_valid cycle", first_out, 12);
    check("nominal in_ready at cycle 13", ir13, 1);

    // ---- key_ack withheld 3 cycles at round 4 ----
    first_out = -1;
    stalls = 0;
    for (int t = 0; t < 17; t++) begin
      if (m_pos == 5 && stalls < 3) begin
        run_cycle(t == 0, 1'b0, 1'b1, 1'b0);
        stalls++;
        check($sformatf("stall%0d key_round", stalls), 32'(obs[9:6]), 32'd4);
      end else begin
        run_cycle(t == 0, 1'b1, 1'b1, 1'b0);
      end
      if (obs[1] && first_out < 0) first_out = t;
    end
    check("stalled first out_valid cycle", first_out, 15);

    // ---- out_ready low 5 cycles in OUT, in_valid held high ----
    loads = 0;
    ovs = 0;
    for (int t = 0; t < 18; t++) begin
      run_cycle(1'b1, 1'b1, t >= 17, 1'b0);
      loads += int'(obs[11]);
      ovs   += int'(obs[1]);
    end
    check("held out_valid cycles", ovs, 6);
    check("loads while busy", loads, 1);
    drain();

    // ---- back-to-back blocks ----
    last_load = -1;
    sr_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
      if (obs[11]) begin
        if (last_load >= 0) begin
          check($sformatf("b2b load gap t%0d", t), t - last_load, 13);
          check($sformatf("b2b enbsr count t%0d", t), sr_cnt, NR);
        end
        last_load = t;
        sr_cnt = 0;
      end
      sr_cnt += int'(obs[4]);
    end
    drain();

    // ---- asynchronous reset in the middle of round 5 ----
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    while (m_pos != 6) run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    bus.key_ack = 1'b1;
    bus.in_valid = 1'b0;
    #2;
    check("pre-reset key_round", 32'(bus.key_round), 32'd5);
    rst_n = 1'b0;
    #1;
    obs = sample();
    check("mid-run reset outputs", 32'(obs), 32'(model_out(0, 1'b0, 1'b1, 1'b0)));
    m_pos = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ovs = 0;
    for (int t = 0; t < 3; t++) begin
      run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
      ovs += int'(obs[1]);
    end
    check("no out_valid after reset", ovs, 0);

`ifdef AES_CTRL_ABORT_EN
    // ---- abort at round 7, then a fresh block ----
    ovs = 0;
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    while (m_pos != 8) run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check("abort cycle enables", 32'(obs[5:2]), 32'd0);
    ovs += int'(obs[1]);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("idle after abort", 32'(obs[12]), 32'd1);
    check("no out_valid for aborted block", ovs, 0);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1);  // abort in IDLE must not mask accept
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("new block restarts at round 0", 32'(obs[9:6]), 32'd0);
    drain();
`endif

    // ---- randomized traffic ----
    for (int t = 0; t < 3000; t++) begin
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_aes_round_ctrl
